// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants, FSM state type, FIFO entry layout and the
//                segment-pattern-to-ASCII decoder for seg7_scan_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Lit-segment patterns (a..g in bits 7..1, dp bit 0 masked to zero)
    localparam logic [7:0] C_PAT_0     = 8'hFC;
    localparam logic [7:0] C_PAT_1     = 8'h60;
    localparam logic [7:0] C_PAT_2     = 8'hDA;
    localparam logic [7:0] C_PAT_3     = 8'hF2;
    localparam logic [7:0] C_PAT_4     = 8'h66;
    localparam logic [7:0] C_PAT_5     = 8'hB6;
    localparam logic [7:0] C_PAT_6     = 8'h3E;
    localparam logic [7:0] C_PAT_7     = 8'hE0;
    localparam logic [7:0] C_PAT_8     = 8'hFE;
    localparam logic [7:0] C_PAT_9     = 8'hE6;
    localparam logic [7:0] C_PAT_BLANK = 8'h00;

    localparam logic [7:0] C_ASCII_0     = 8'h30;
    localparam logic [7:0] C_ASCII_SPACE = 8'h20;
    localparam logic [7:0] C_ASCII_QMARK = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } seg7_state_t;

    typedef struct packed {
        logic [7:0] ch;
        logic [2:0] idx;
        logic       err;
        logic       dp;
    } seg7_entry_t;

    localparam int C_ENTRY_W = $bits(seg7_entry_t);

    // Returns {err, ascii}; takes the raw active-low bus and ignores dp.
    function automatic logic [8:0] seg7_decode(input logic [7:0] seg_n);
        logic [7:0] pat;
        logic [8:0] res;
        pat = ~seg_n & 8'hFE;
        case (pat)
            C_PAT_0:     res = {1'b0, C_ASCII_0};
            C_PAT_1:     res = {1'b0, C_ASCII_0 + 8'd1};
            C_PAT_2:     res = {1'b0, C_ASCII_0 + 8'd2};
            C_PAT_3:     res = {1'b0, C_ASCII_0 + 8'd3};
            C_PAT_4:     res = {1'b0, C_ASCII_0 + 8'd4};
            C_PAT_5:     res = {1'b0, C_ASCII_0 + 8'd5};
            C_PAT_6:     res = {1'b0, C_ASCII_0 + 8'd6};
            C_PAT_7:     res = {1'b0, C_ASCII_0 + 8'd7};
            C_PAT_8:     res = {1'b0, C_ASCII_0 + 8'd8};
            C_PAT_9:     res = {1'b0, C_ASCII_0 + 8'd9};
            C_PAT_BLANK: res = {1'b0, C_ASCII_SPACE};
            default:     res = {1'b1, C_ASCII_QMARK};
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_char_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_char_fifo
//  Description : Power-of-two deep character FIFO with valid/ready read side;
//                a push while full is accepted only alongside a pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_char_fifo
    import seg7_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [C_ENTRY_W-1:0] i_wr_data,
    input  logic                 i_rd_ready,
    output logic                 o_rd_valid,
    output logic [C_ENTRY_W-1:0] o_rd_data,
    output logic                 o_full
);

    localparam int              C_AW   = $clog2(DEPTH);
    localparam logic [C_AW:0]   C_FULL = DEPTH[C_AW:0];

    logic [C_ENTRY_W-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]      r_wr_ptr;
    logic [C_AW-1:0]      r_rd_ptr;
    logic [C_AW:0]        r_count;
    logic                 w_pop;
    logic                 w_push;

    assign o_rd_valid = (r_count != '0);
    assign o_full     = (r_count == C_FULL);
    assign w_pop      = o_rd_valid & i_rd_ready;
    assign w_push     = i_wr_en & (~o_full | w_pop);
    // Empty FIFO presents all-zero fields so reset values hold on out_*.
    assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_decoder
//  Description : Samples a multiplexed 7-segment display bus, debounces each
//                digit, decodes it to ASCII and queues changed characters.
//                Define SEG7_DP_DECODE_EN to report the decimal point.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg_n,
    input  logic [NUM_DIGITS-1:0] dig_n,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_char,
    output logic [2:0]            out_idx,
    output logic                  out_err,
    output logic                  out_dp,
    output logic                  ovf
);

    localparam int                C_CW       = $clog2(STABLE_CYCLES);
    localparam int                C_PW       = 8 + NUM_DIGITS;
    localparam logic [C_CW-1:0]   C_CNT_LAST = C_CW'(STABLE_CYCLES - 1);

    logic [7:0]            r_seg_s1;
    logic [7:0]            r_seg_s2;
    logic [NUM_DIGITS-1:0] r_dig_s1;
    logic [NUM_DIGITS-1:0] r_dig_s2;

    seg7_state_t           r_state;
    logic [C_CW-1:0]       r_cnt;
    logic [C_PW-1:0]       r_prev;
    logic [8:0]            r_last [NUM_DIGITS];
    logic                  r_ovf;

    logic [7:0]            w_seg;
    logic                  w_dp;
    logic [C_PW-1:0]       w_pair;
    logic [3:0]            w_zeros;
    logic [2:0]            w_idx;
    logic                  w_onehot;
    logic                  w_changed;
    logic                  w_capture;
    logic [8:0]            w_dec;
    logic [7:0]            w_ch;
    logic                  w_err;
    logic [8:0]            w_last_sel;
    logic                  w_wr_en;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_valid;
    seg7_entry_t           w_entry;
    seg7_entry_t           w_head;
    logic [C_ENTRY_W-1:0]  w_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_s1 <= '1;
            r_seg_s2 <= '1;
            r_dig_s1 <= '1;
            r_dig_s2 <= '1;
        end else begin
            r_seg_s1 <= seg_n;
            r_seg_s2 <= r_seg_s1;
            r_dig_s1 <= dig_n;
            r_dig_s2 <= r_dig_s1;
        end
    end

`ifdef SEG7_DP_DECODE_EN
    assign w_seg = r_seg_s2;
    assign w_dp  = ~r_seg_s2[0];
`else
    // dp forced dark so it never disturbs the filter or the change check
    logic w_unused_dp;
    assign w_unused_dp = r_seg_s2[0];
    assign w_seg       = {r_seg_s2[7:1], 1'b1};
    assign w_dp        = 1'b0;
`endif

    assign w_pair = {w_seg, r_dig_s2};

    always_comb begin
        w_zeros = 4'd0;
        w_idx   = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_dig_s2[i]) begin
                w_zeros = w_zeros + 4'd1;
                w_idx   = i[2:0];
            end
        end
    end

    assign w_onehot  = (w_zeros == 4'd1);
    assign w_changed = (w_pair != r_prev);
    assign w_capture = (r_state == ST_COUNT) && !w_changed && (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_prev  <= '1;
        end else begin
            r_prev <= w_pair;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_onehot) begin
                        r_state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (!w_onehot) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_changed) begin
                        r_cnt   <= '0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_state <= ST_HELD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    r_cnt <= '0;
                    if (!w_onehot) begin
                        r_state <= ST_IDLE;
                    end else if (w_changed) begin
                        r_state <= ST_COUNT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_dec = seg7_decode(w_seg);
    assign w_ch  = w_dec[7:0];
    assign w_err = w_dec[8];

    always_comb begin
        w_last_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx == i[2:0]) begin
                w_last_sel = r_last[i];
            end
        end
    end

    // Only characters that differ from what was last reported for the digit move on.
    assign w_wr_en  = w_capture && ({w_ch, w_dp} != w_last_sel);
    assign w_pop    = w_valid & out_ready;
    assign w_accept = w_wr_en & (~w_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_last[i] <= '0;
            end
            r_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_accept && (w_idx == i[2:0])) begin
                    r_last[i] <= {w_ch, w_dp};
                end
            end
            if (w_wr_en && !w_accept) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign w_entry.ch  = w_ch;
    assign w_entry.idx = w_idx;
    assign w_entry.err = w_err;
    assign w_entry.dp  = w_dp;

    seg7_char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_accept),
        .i_wr_data  (w_entry),
        .i_rd_ready (out_ready),
        .o_rd_valid (w_valid),
        .o_rd_data  (w_rd_data),
        .o_full     (w_full)
    );

    assign w_head    = w_rd_data;
    assign out_valid = w_valid;
    assign out_char  = w_head.ch;
    assign out_idx   = w_head.idx;
    assign out_err   = w_head.err;
    assign out_dp    = w_head.dp;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_decoder
//  Description : Self-checking bench for seg7_scan_decoder against a run-length
//                based reference model with directed and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 8;
    localparam int FD = 4;
`ifdef SEG7_DP_DECODE_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    seg_n = '1;
    logic [ND-1:0] dig_n = '1;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [7:0]    out_char;
    logic [2:0]    out_idx;
    logic          out_err;
    logic          out_dp;
    logic          ovf;

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_n     (seg_n),
        .dig_n     (dig_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_idx   (out_idx),
        .out_err   (out_err),
        .out_dp    (out_dp),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] ch;
        logic [2:0] idx;
        logic       err;
        logic       dp;
    } ent_t;

    logic [7:0] tbl_pat [11] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6,
                                 8'h3E, 8'hE0, 8'hFE, 8'hE6, 8'h00};
    logic [7:0] tbl_chr [11] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                                 8'h36, 8'h37, 8'h38, 8'h39, 8'h20};

    ent_t             mq [$];
    logic [8+ND-1:0]  pin_q [$];
    logic [8:0]       m_last [ND];
    logic             m_ovf;
    logic [8+ND-1:0]  run_val;
    int               run_len;
    int               edge_cnt  = 0;
    int               delivered = 0;
    logic [8:0]       got_q [$];

    task automatic model_reset();
        mq.delete();
        pin_q.delete();
        for (int i = 0; i < ND; i++) m_last[i] = '0;
        m_ovf   = 1'b0;
        run_val = '1;
        run_len = 0;
    endtask

    always @(posedge clk) begin : p_model
        logic [8+ND-1:0] smp;
        logic [7:0]      sg;
        logic [7:0]      pat;
        logic            pop;
        logic            acc;
        int              d;
        ent_t            e;
        if (rst) begin
            model_reset();
        end else begin
            edge_cnt++;
            pop = out_ready && (mq.size() > 0);
            acc = 1'b0;
            pin_q.push_back({DP_EN ? seg_n : {seg_n[7:1], 1'b1}, dig_n});
            if (pin_q.size() > 3) void'(pin_q.pop_front());
            smp = (pin_q.size() == 3) ? pin_q[0] : '1;
            // a capture happens when a one-hot pair has been seen SC+1 samples in a row
            if ($countones(~smp[ND-1:0]) == 1) begin
                if (smp == run_val) run_len++;
                else begin
                    run_val = smp;
                    run_len = 1;
                end
            end else begin
                run_val = smp;
                run_len = 0;
            end
            if (run_len == SC + 1) begin
                d = 0;
                for (int i = 0; i < ND; i++) if (!smp[i]) d = i;
                sg     = smp[8+ND-1:ND];
                pat    = ~sg & 8'hFE;
                e.ch   = 8'h3F;
                e.err  = 1'b1;
                for (int i = 0; i < 11; i++) begin
                    if (pat == tbl_pat[i]) begin
                        e.ch  = tbl_chr[i];
                        e.err = 1'b0;
                    end
                end
                e.idx = 3'(d);
                e.dp  = DP_EN ? ~sg[0] : 1'b0;
                if ({e.ch, e.dp} != m_last[d]) begin
                    if ((mq.size() < FD) || pop) begin
                        acc       = 1'b1;
                        m_last[d] = {e.ch, e.dp};
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        #1;
        chk("m_valid", out_valid, mq.size() != 0);
        chk("m_ovf", ovf, m_ovf);
        if (mq.size() != 0) begin
            chk("m_char", out_char, mq[0].ch);
            chk("m_idx",  out_idx,  mq[0].idx);
            chk("m_err",  out_err,  mq[0].err);
            chk("m_dp",   out_dp,   mq[0].dp);
        end
    end

    // handshake observer, sampled mid-cycle after inputs settle
    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) begin
            delivered++;
            got_q.push_back({out_dp, out_char});
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_ready = 1'b0;

    task automatic show(input logic [ND-1:0] d, input logic [7:0] pat, input int cyc);
        dig_n = d;
        seg_n = ~pat;
        repeat (cyc) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        dig_n     = '1;
        seg_n     = '1;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : p_watchdog
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : p_main
        int e0;
        int lat;
        int base;
        int gb;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_char",  out_char, 8'h00);
        chk("rst_idx",   out_idx, 0);
        chk("rst_err",   out_err, 0);
        chk("rst_dp",    out_dp, 0);
        chk("rst_ovf",   ovf, 0);
        rst = 1'b0;

        // first capture latency and content
        dig_n = 4'b1110;
        seg_n = ~8'hFC;
        e0    = edge_cnt;
        lat   = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (out_valid && lat < 0) lat = edge_cnt - e0;
        end
        chk("lat_edges", lat, 11);
        chk("first_char", out_char, 8'h30);
        chk("first_idx", out_idx, 0);
        chk("first_err", out_err, 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("single_out", out_valid, 0);

        // short hold ignored, unchanged re-show suppressed
        do_reset();
        out_ready = 1'b1;
        base = delivered;
        gb   = got_q.size();
        show(4'b1110, 8'h60, 7);
        show(4'b1101, 8'hDA, 20);
        show(4'b1110, 8'hF2, 20);
        show(4'b1101, 8'hDA, 20);
        show(4'b1111, 8'h00, 5);
        chk("repeat_count", delivered - base, 2);
        if (got_q.size() >= gb + 2) begin
            chk("repeat_c0", got_q[gb][7:0], 8'h32);
            chk("repeat_c1", got_q[gb+1][7:0], 8'h33);
        end

        // unrecognised pattern
        do_reset();
        show(4'b1011, 8'hA5, 20);
        chk("bad_char", out_char, 8'h3F);
        chk("bad_err", out_err, 1);
        chk("bad_idx", out_idx, 2);

        // overflow drops the fifth capture
        do_reset();
        show(4'b1110, 8'h60, 14);
        show(4'b1101, 8'hDA, 14);
        show(4'b1011, 8'hF2, 14);
        show(4'b0111, 8'h66, 14);
        show(4'b1110, 8'hB6, 14);
        chk("ovf_set", ovf, 1);
        base = delivered;
        gb   = got_q.size();
        out_ready = 1'b1;
        show(4'b1111, 8'h00, 10);
        chk("ovf_drain", delivered - base, 4);
        if (got_q.size() >= gb + 4) begin
            chk("ovf_o0", got_q[gb][7:0],   8'h31);
            chk("ovf_o1", got_q[gb+1][7:0], 8'h32);
            chk("ovf_o2", got_q[gb+2][7:0], 8'h33);
            chk("ovf_o3", got_q[gb+3][7:0], 8'h34);
        end

        // full FIFO with pop and push on the same edge
        do_reset();
        show(4'b1110, 8'h60, 14);
        show(4'b1101, 8'hDA, 14);
        show(4'b1011, 8'hF2, 14);
        show(4'b0111, 8'h66, 14);
        base  = delivered;
        gb    = got_q.size();
        dig_n = 4'b1110;
        seg_n = ~8'h3E;
        repeat (10) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("pp_ovf", ovf, 0);
        chk("pp_one_pop", delivered - base, 1);
        out_ready = 1'b1;
        show(4'b1111, 8'h00, 8);
        chk("pp_total", delivered - base, 5);
        if (got_q.size() >= gb + 5) chk("pp_last", got_q[gb+4][7:0], 8'h36);

        // two digits enabled at once, then reset while valid
        do_reset();
        out_ready = 1'b1;
        base = delivered;
        show(4'b1100, 8'h60, 30);
        chk("twohot_none", delivered - base, 0);
        out_ready = 1'b0;
        show(4'b1110, 8'hE0, 14);
        chk("pre_rst_valid", out_valid, 1);
        dig_n = '1;
        seg_n = '1;
        rst   = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_empty", out_valid, 0);
        chk("rst_mid_ovf", ovf, 0);

        // decimal point on an unchanged digit
        do_reset();
        out_ready = 1'b1;
        base = delivered;
        gb   = got_q.size();
        show(4'b1110, 8'hB6, 14);
        show(4'b1110, 8'hB7, 14);
        show(4'b1111, 8'h00, 4);
        chk("dp_count", delivered - base, DP_EN ? 2 : 1);
        if (DP_EN && got_q.size() >= gb + 2) chk("dp_flag", got_q[gb+1][8], 1);

        // random traffic against the model
        do_reset();
        rnd_ready = 1'b1;
        for (int k = 0; k < 250; k++) begin
            int            dd;
            logic [ND-1:0] dv;
            logic [7:0]    pv;
            dd     = $urandom_range(0, ND - 1);
            dv     = '1;
            dv[dd] = 1'b0;
            if ($urandom_range(0, 7) == 0) dv = ND'($urandom);
            if ($urandom_range(0, 5) == 0) pv = 8'($urandom);
            else pv = tbl_pat[$urandom_range(0, 10)] | 8'($urandom_range(0, 1));
            show(dv, pv, $urandom_range(1, 14));
            if (k % 80 == 79) do_reset();
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        show(4'b1111, 8'h00, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
